// File: rtl/data_mem_lsu.sv
// Purpose : byte-addressable little-endian data memory with an RV32I load/store front end.
// Latency : request accepted at edge N completes with a one-cycle rvalid_o after edge N+WAIT_STATES+1.
// Backpr. : ready_o is low from the cycle after accept until rvalid_o has been seen; req_i is ignored then.
//
// Ports:
//   clk_i      system clock, rising edge
//   rst_ni     asynchronous active-low reset (state/outputs only, array keeps contents)
//   req_i      access request, accepted when ready_o=1
//   we_i       1 = store, 0 = load (sampled on accept)
//   funct3_i   RV32I size/sign encoding (sampled on accept)
//   addr_i     byte address (sampled on accept)
//   wdata_i    store data, low bytes used per size (sampled on accept)
//   ready_o    block can accept a request this cycle
//   rvalid_o   one-cycle completion pulse for loads and stores
//   rdata_o    extended load result, valid while rvalid_o=1
//   err_o      access faulted, valid while rvalid_o=1
module data_mem_lsu #(
    parameter int DEPTH_BYTES = 4096,
    parameter int WAIT_STATES = 0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        ready_o,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    localparam int AW = $clog2(DEPTH_BYTES);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // WAIT always lasts WAIT_STATES+1 cycles: one base cycle for address
    // decode plus the configured wait states, so the counter starts at
    // WAIT_STATES and DONE is entered when it reads zero.
    localparam logic [3:0] WS_CNT = 4'(WAIT_STATES);

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q;

    logic [7:0]  mem_q [DEPTH_BYTES];

    logic        accept;
    logic        enter_done;

    assign accept     = (state_q == ST_IDLE) && req_i;
    assign enter_done = (state_q == ST_WAIT) && (cnt_q == 4'd0);

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req_i) begin
                    state_d = ST_WAIT;
                    cnt_d   = WS_CNT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Request fields are captured once on accept and held for the access.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            we_q    <= 1'b0;
            f3_q    <= 3'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
        end else if (accept) begin
            we_q    <= we_i;
            f3_q    <= funct3_i;
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
        end
    end

    // ------------------------------------------------------------------
    // Size decode and fault detection on the latched request
    // ------------------------------------------------------------------
    logic [2:0] size_bytes;
    logic       size_ok;
    logic       misalign;
    logic       out_of_range;
    logic       acc_err;

    always_comb begin
        case (f3_q[1:0])
            2'b00:   size_bytes = 3'd1;
            2'b01:   size_bytes = 3'd2;
            default: size_bytes = 3'd4;
        endcase
    end

    always_comb begin
        size_ok = 1'b0;
        if (we_q) begin
            size_ok = (f3_q == 3'b000) || (f3_q == 3'b001) || (f3_q == 3'b010);
        end else begin
            size_ok = (f3_q == 3'b000) || (f3_q == 3'b001) || (f3_q == 3'b010) ||
                      (f3_q == 3'b100) || (f3_q == 3'b101);
        end
    end

    assign misalign = ((f3_q[1:0] == 2'b01) && addr_q[0]) ||
                      ((f3_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00));

    // Full 32-bit compare in 33 bits so addresses beyond the array never
    // alias onto low locations through the truncated index.
    assign out_of_range = ({1'b0, addr_q} + 33'(size_bytes)) > 33'(DEPTH_BYTES);

    assign acc_err = !size_ok || misalign || out_of_range;

    // ------------------------------------------------------------------
    // Byte array
    // ------------------------------------------------------------------
    logic [AW-1:0] idx0, idx1, idx2, idx3;
    logic          wr_en;

    assign idx0 = addr_q[AW-1:0];
    assign idx1 = idx0 + AW'(1);
    assign idx2 = idx0 + AW'(2);
    assign idx3 = idx0 + AW'(3);

    // Stores commit on the same edge that enters DONE; a reset that lands
    // before that edge returns the FSM to IDLE and the write never happens.
    assign wr_en = enter_done && we_q && !acc_err;

    always_ff @(posedge clk_i) begin
        if (wr_en && rst_ni) begin
            mem_q[idx0] <= wdata_q[7:0];
            if (size_bytes != 3'd1) begin
                mem_q[idx1] <= wdata_q[15:8];
            end
            if (size_bytes == 3'd4) begin
                mem_q[idx2] <= wdata_q[23:16];
                mem_q[idx3] <= wdata_q[31:24];
            end
        end
    end

    // ------------------------------------------------------------------
    // Load extension and result registers
    // ------------------------------------------------------------------
    logic [7:0]  b0, b1, b2, b3;
    logic [31:0] load_val;

    assign b0 = mem_q[idx0];
    assign b1 = mem_q[idx1];
    assign b2 = mem_q[idx2];
    assign b3 = mem_q[idx3];

    always_comb begin
        case (f3_q)
            3'b000:  load_val = {{24{b0[7]}}, b0};
            3'b001:  load_val = {{16{b1[7]}}, b1, b0};
            3'b010:  load_val = {b3, b2, b1, b0};
            3'b100:  load_val = {24'd0, b0};
            3'b101:  load_val = {16'd0, b1, b0};
            default: load_val = 32'd0;
        endcase
    end

    // Stores and faulted accesses report zero data.
    assign rdata_d = (we_q || acc_err) ? 32'd0 : load_val;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else if (enter_done) begin
            rdata_q <= rdata_d;
            err_q   <= acc_err;
        end
    end

    assign ready_o  = (state_q == ST_IDLE);
    assign rvalid_o = (state_q == ST_DONE);
    assign rdata_o  = rdata_q;
    assign err_o    = err_q;

endmodule

// File: tb/tb_data_mem_lsu.sv
// Purpose : directed self-checking bench for data_mem_lsu with zero and three wait states.
// Latency : n/a (testbench).
// Backpr. : n/a (testbench).
module tb_data_mem_lsu;

    logic        clk;
    logic        rst_ni;

    logic        req0, we0;
    logic [2:0]  f3_0;
    logic [31:0] addr0, wdata0;
    logic        ready0, rvalid0, err0;
    logic [31:0] rdata0;

    logic        req3, we3;
    logic [2:0]  f3_3;
    logic [31:0] addr3, wdata3;
    logic        ready3, rvalid3, err3;
    logic [31:0] rdata3;

    int checks = 0;
    int passes = 0;

    data_mem_lsu #(.DEPTH_BYTES(4096), .WAIT_STATES(0)) u_ws0 (
        .clk_i    (clk),
        .rst_ni   (rst_ni),
        .req_i    (req0),
        .we_i     (we0),
        .funct3_i (f3_0),
        .addr_i   (addr0),
        .wdata_i  (wdata0),
        .ready_o  (ready0),
        .rvalid_o (rvalid0),
        .rdata_o  (rdata0),
        .err_o    (err0)
    );

    data_mem_lsu #(.DEPTH_BYTES(4096), .WAIT_STATES(3)) u_ws3 (
        .clk_i    (clk),
        .rst_ni   (rst_ni),
        .req_i    (req3),
        .we_i     (we3),
        .funct3_i (f3_3),
        .addr_i   (addr3),
        .wdata_i  (wdata3),
        .ready_o  (ready3),
        .rvalid_o (rvalid3),
        .rdata_o  (rdata3),
        .err_o    (err3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) passes++;
        else $error("FAIL %s: observed %08h expected %08h", tag, got, exp);
    endtask

    // One complete access on the chosen instance. lat counts clock edges
    // after the accept edge until rvalid is seen; rdy_busy is ready in the
    // cycle after accept; rdy_after/rv_after are sampled one edge after rvalid.
    task automatic do_acc(input bit w3, input bit we, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er, output int lat,
                          output logic rdy_busy, output logic rdy_after,
                          output logic rv_after);
        int guard;
        guard = 0;
        while (!(w3 ? ready3 : ready0) && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (w3) begin
            req3 = 1'b1; we3 = we; f3_3 = f3; addr3 = a; wdata3 = wd;
        end else begin
            req0 = 1'b1; we0 = we; f3_0 = f3; addr0 = a; wdata0 = wd;
        end
        @(posedge clk); #1;
        req0 = 1'b0;
        req3 = 1'b0;
        rdy_busy = w3 ? ready3 : ready0;
        lat = 0;
        while (!(w3 ? rvalid3 : rvalid0) && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = w3 ? rdata3 : rdata0;
        er = w3 ? err3 : err0;
        @(posedge clk); #1;
        rdy_after = w3 ? ready3 : ready0;
        rv_after  = w3 ? rvalid3 : rvalid0;
    endtask

    initial begin
        logic [31:0] rd;
        logic        er, rb, ra, rva;
        int          lat;
        int          pulses;

        rst_ni = 1'b0;
        req0 = 1'b0; we0 = 1'b0; f3_0 = 3'd0; addr0 = 32'd0; wdata0 = 32'd0;
        req3 = 1'b0; we3 = 1'b0; f3_3 = 3'd0; addr3 = 32'd0; wdata3 = 32'd0;

        #3;
        chk("rst_ready0",  {31'd0, ready0},  32'd1);
        chk("rst_rvalid0", {31'd0, rvalid0}, 32'd0);
        chk("rst_rdata0",  rdata0,           32'd0);
        chk("rst_err0",    {31'd0, err0},    32'd0);
        chk("rst_ready3",  {31'd0, ready3},  32'd1);
        chk("rst_rvalid3", {31'd0, rvalid3}, 32'd0);
        @(posedge clk); #1;
        rst_ni = 1'b1;
        @(posedge clk); #1;

        // ---------------- zero wait states ----------------
        do_acc(0, 1, 3'b010, 32'h10, 32'hDEADBEEF, rd, er, lat, rb, ra, rva);
        chk("sw10_lat",  lat, 1);
        chk("sw10_err",  {31'd0, er}, 32'd0);
        chk("sw10_pulse_one_cycle", {31'd0, rva}, 32'd0);
        chk("sw10_ready_back", {31'd0, ra}, 32'd1);

        do_acc(0, 0, 3'b010, 32'h10, 32'h0, rd, er, lat, rb, ra, rva);
        chk("lw10_lat",   lat, 1);
        chk("lw10_rdata", rd, 32'hDEADBEEF);
        chk("lw10_err",   {31'd0, er}, 32'd0);
        chk("lw10_rdata_hold", rdata0, 32'hDEADBEEF);

        do_acc(0, 0, 3'b000, 32'h13, 32'h0, rd, er, lat, rb, ra, rva);
        chk("lb13", rd, 32'hFFFFFFDE);
        do_acc(0, 0, 3'b100, 32'h13, 32'h0, rd, er, lat, rb, ra, rva);
        chk("lbu13", rd, 32'h000000DE);
        do_acc(0, 0, 3'b001, 32'h12, 32'h0, rd, er, lat, rb, ra, rva);
        chk("lh12", rd, 32'hFFFFDEAD);
        do_acc(0, 0, 3'b101, 32'h10, 32'h0, rd, er, lat, rb, ra, rva);
        chk("lhu10", rd, 32'h0000BEEF);

        do_acc(0, 1, 3'b000, 32'h11, 32'h12345677, rd, er, lat, rb, ra, rva);
        chk("sb11_err", {31'd0, er}, 32'd0);
        do_acc(0, 0, 3'b010, 32'h10, 32'h0, rd, er, lat, rb, ra, rva);
        chk("lw10_after_sb", rd, 32'hDEAD77EF);

        do_acc(0, 0, 3'b001, 32'h11, 32'h0, rd, er, lat, rb, ra, rva);
        chk("lh11_misalign_err",   {31'd0, er}, 32'd1);
        chk("lh11_misalign_rdata", rd, 32'd0);
        chk("lh11_lat", lat, 1);

        do_acc(0, 1, 3'b010, 32'h20, 32'h01020304, rd, er, lat, rb, ra, rva);
        do_acc(0, 1, 3'b010, 32'h22, 32'hFFFFFFFF, rd, er, lat, rb, ra, rva);
        chk("sw22_misalign_err", {31'd0, er}, 32'd1);
        do_acc(0, 0, 3'b010, 32'h20, 32'h0, rd, er, lat, rb, ra, rva);
        chk("lw20_unchanged", rd, 32'h01020304);

        do_acc(0, 0, 3'b010, 32'd4094, 32'h0, rd, er, lat, rb, ra, rva);
        chk("lw_depth_m2_err", {31'd0, er}, 32'd1);
        do_acc(0, 0, 3'b010, 32'd4092, 32'h0, rd, er, lat, rb, ra, rva);
        chk("lw_depth_m4_ok", {31'd0, er}, 32'd0);
        do_acc(0, 1, 3'b000, 32'd4095, 32'h0000005A, rd, er, lat, rb, ra, rva);
        chk("sb_last_ok", {31'd0, er}, 32'd0);
        do_acc(0, 0, 3'b100, 32'd4095, 32'h0, rd, er, lat, rb, ra, rva);
        chk("lbu_last", rd, 32'h0000005A);

        // An address past the array must fault, not alias onto byte 0.
        do_acc(0, 1, 3'b010, 32'h0, 32'hA5A5A5A5, rd, er, lat, rb, ra, rva);
        do_acc(0, 1, 3'b010, 32'h1000, 32'h11111111, rd, er, lat, rb, ra, rva);
        chk("sw_4096_err", {31'd0, er}, 32'd1);
        do_acc(0, 0, 3'b010, 32'h0, 32'h0, rd, er, lat, rb, ra, rva);
        chk("lw0_no_alias", rd, 32'hA5A5A5A5);

        do_acc(0, 0, 3'b011, 32'h10, 32'h0, rd, er, lat, rb, ra, rva);
        chk("load_f3_011_err",   {31'd0, er}, 32'd1);
        chk("load_f3_011_rdata", rd, 32'd0);
        do_acc(0, 1, 3'b100, 32'h10, 32'h00000000, rd, er, lat, rb, ra, rva);
        chk("store_f3_100_err", {31'd0, er}, 32'd1);
        do_acc(0, 0, 3'b010, 32'h10, 32'h0, rd, er, lat, rb, ra, rva);
        chk("lw10_after_bad_store", rd, 32'hDEAD77EF);

        // ---------------- three wait states ----------------
        do_acc(1, 1, 3'b010, 32'h40, 32'h11223344, rd, er, lat, rb, ra, rva);
        chk("ws3_sw_lat",        lat, 4);
        chk("ws3_ready_busy",    {31'd0, rb},  32'd0);
        chk("ws3_ready_after",   {31'd0, ra},  32'd1);
        chk("ws3_rvalid_single", {31'd0, rva}, 32'd0);
        do_acc(1, 0, 3'b010, 32'h40, 32'h0, rd, er, lat, rb, ra, rva);
        chk("ws3_lw40", rd, 32'h11223344);
        chk("ws3_lw_lat", lat, 4);

        // req held through the busy window: only one access may result.
        req3 = 1'b1; we3 = 1'b1; f3_3 = 3'b010; addr3 = 32'h50; wdata3 = 32'hAABBCCDD;
        pulses = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (rvalid3) pulses++;
        end
        req3 = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (rvalid3) pulses++;
        end
        chk("ws3_held_req_pulses", pulses, 1);
        do_acc(1, 0, 3'b010, 32'h50, 32'h0, rd, er, lat, rb, ra, rva);
        chk("ws3_lw50", rd, 32'hAABBCCDD);

        // Reset in the middle of WAIT aborts the store.
        req3 = 1'b1; we3 = 1'b1; f3_3 = 3'b010; addr3 = 32'h40; wdata3 = 32'hCAFEF00D;
        @(posedge clk); #1;
        req3 = 1'b0;
        @(posedge clk); #1;
        rst_ni = 1'b0;
        #1;
        chk("rst_mid_ready3",  {31'd0, ready3},  32'd1);
        chk("rst_mid_rvalid3", {31'd0, rvalid3}, 32'd0);
        chk("rst_mid_rdata3",  rdata3,           32'd0);
        @(posedge clk); #1;
        rst_ni = 1'b1;
        @(posedge clk); #1;
        do_acc(1, 0, 3'b010, 32'h40, 32'h0, rd, er, lat, rb, ra, rva);
        chk("ws3_lw40_after_abort", rd, 32'h11223344);
        chk("ws3_lw40_after_abort_err", {31'd0, er}, 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
